// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg
// Shared definitions for the MEM/WB pipeline stage: the stall FSM state type,
// default widths, and the helper that sizes the SRAM wait counter.
package mem_wb_stage_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int REG_AW_DEF   = 4;
    localparam int WAIT_MAX_DEF = 15;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_e;

    // Counter must hold 0..wait_max inclusive; never let it collapse to 0 bits.
    function automatic int cnt_width(input int wait_max);
        int w;
        w = $clog2(wait_max + 1);
        return (w < 1) ? 1 : w;
    endfunction

    localparam int CNT_W_DEF = cnt_width(WAIT_MAX_DEF);

endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if
// Bundles the memory-stage inputs, the SRAM completion handshake and the
// write-back / stall outputs of the MEM/WB stage.
//   master : the pipeline side that drives the memory-stage results and ready
//   slave  : the MEM/WB stage itself
// Signals:
//   WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, Dest_in, ALU_res_in : memory-stage results
//   DATA_in, ready  : SRAM read data and access-complete strobe
//   freeze          : pipeline-wide stall request
//   WB_EN, WB_Dest, WB_Value : register-file write port
//   timeout         : sticky flag, an SRAM access overran its wait budget
interface mem_wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
);
    logic              WB_EN_in;
    logic              MEM_R_EN_in;
    logic              MEM_W_EN_in;
    logic [REG_AW-1:0] Dest_in;
    logic [DATA_W-1:0] ALU_res_in;
    logic [DATA_W-1:0] DATA_in;
    logic              ready;

    logic              freeze;
    logic              WB_EN;
    logic [REG_AW-1:0] WB_Dest;
    logic [DATA_W-1:0] WB_Value;
    logic              timeout;

    modport master (
        output WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, Dest_in, ALU_res_in, DATA_in, ready,
        input  freeze, WB_EN, WB_Dest, WB_Value, timeout
    );

    modport slave (
        input  WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, Dest_in, ALU_res_in, DATA_in, ready,
        output freeze, WB_EN, WB_Dest, WB_Value, timeout
    );
endinterface

// File: rtl/mem_wb_stage_wb_select.sv
// mem_wb_stage_wb_select
// Write-back value select: load data for loads, ALU result otherwise.
// Purely combinational so the forwarding path can reuse it unchanged.
// Ports:
//   mem_r     in  : the registered instruction is a load
//   alu_res   in  : registered ALU result
//   load_data in  : registered SRAM read data
//   wb_value  out : value written to the register file
module mem_wb_stage_wb_select #(
    parameter int DATA_W = 32
) (
    input  logic              mem_r,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] wb_value
);

    assign wb_value = mem_r ? load_data : alu_res;

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage
// MEM/WB pipeline register with write-back select and SRAM stall control.
// Memory-stage results are captured only when no SRAM access is pending;
// while one is pending the whole pipeline is frozen and a bubble is fed to
// write-back. A wait counter flags (sticky) any access that runs WAIT_MAX
// cycles in the WAIT state; the access itself is never aborted.
// Ports:
//   clk          : pipeline clock, rising edge
//   rst          : asynchronous, active-low reset
//   bus          : mem_wb_stage_if.slave (memory-stage inputs, SRAM ready,
//                  freeze, register-file write port, timeout)
//   stall_cycles : free-running count of frozen cycles (only when
//                  MEM_WB_STALL_CNT_EN is defined)
// Build option: MEM_WB_STALL_CNT_EN adds the stall_cycles output and counter.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int REG_AW   = REG_AW_DEF,
    parameter int WAIT_MAX = WAIT_MAX_DEF
) (
    input logic           clk,
    input logic           rst,
    mem_wb_stage_if.slave bus
`ifdef MEM_WB_STALL_CNT_EN
    ,
    output logic [31:0]   stall_cycles
`endif
);

    localparam int CNT_W = cnt_width(WAIT_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    logic              mem_op;
    logic              freeze;

    state_e            state;
    state_e            state_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  wait_cnt_nxt;
    logic              timeout_r;
    logic              timeout_set;

    logic              wb_en_p1;
    logic [REG_AW-1:0] dest_p1;
    logic [DATA_W-1:0] alu_p1;
    logic              mem_r_p1;
    logic [DATA_W-1:0] data_p1;
    logic [DATA_W-1:0] wb_value;

    // A memory op without its completion strobe stalls this very cycle.
    assign mem_op = bus.MEM_R_EN_in | bus.MEM_W_EN_in;
    assign freeze = mem_op & ~bus.ready;

    // The counter value equals the index of the WAIT cycle being entered, so
    // timeout is already visible during the WAIT_MAX-th WAIT cycle.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        timeout_set  = 1'b0;
        case (state)
            RUN:     if (freeze)    state_nxt = WAIT;
            WAIT:    if (bus.ready) state_nxt = RUN;
            default:                state_nxt = RUN;
        endcase
        if (state_nxt == WAIT) begin
            wait_cnt_nxt = sat_inc(wait_cnt);
            timeout_set  = (wait_cnt_nxt == CNT_MAX);
        end else begin
            wait_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            timeout_r <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            timeout_r <= timeout_r | timeout_set;
        end
    end

    // ---- MEM -> WB register (p1) ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en_p1 <= 1'b0;
            dest_p1  <= '0;
            alu_p1   <= '0;
            mem_r_p1 <= 1'b0;
            data_p1  <= '0;
        end else if (!freeze) begin
            wb_en_p1 <= bus.WB_EN_in;
            dest_p1  <= bus.Dest_in;
            alu_p1   <= bus.ALU_res_in;
            mem_r_p1 <= bus.MEM_R_EN_in;
            data_p1  <= bus.DATA_in;
        end else begin
            // Bubble: only the write enable drops, the payload is held.
            wb_en_p1 <= 1'b0;
        end
    end

    mem_wb_stage_wb_select #(
        .DATA_W (DATA_W)
    ) wb_select (
        .mem_r     (mem_r_p1),
        .alu_res   (alu_p1),
        .load_data (data_p1),
        .wb_value  (wb_value)
    );

    assign bus.freeze   = freeze;
    assign bus.WB_EN    = wb_en_p1;
    assign bus.WB_Dest  = dest_p1;
    assign bus.WB_Value = wb_value;
    assign bus.timeout  = timeout_r;

`ifdef MEM_WB_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (freeze) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage
// Bench for mem_wb_stage: directed scenarios followed by randomized
// instruction streams, compared every cycle against a behavioural model.
// Build option: MEM_WB_STALL_CNT_EN also checks the stall_cycles output.
module tb_mem_wb_stage;
    import mem_wb_stage_pkg::*;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int WM = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_wb_stage_if #(.DATA_W(DW), .REG_AW(AW)) bus ();

`ifdef MEM_WB_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    mem_wb_stage #(
        .DATA_W   (DW),
        .REG_AW   (AW),
        .WAIT_MAX (WM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus)
`ifdef MEM_WB_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: what write-back should show, and stall bookkeeping.
    logic          exp_en;
    logic [AW-1:0] exp_dest;
    logic [DW-1:0] exp_val;
    logic          exp_to;
    int            stall_run;     // consecutive stalled edges of the current access
    logic [31:0]   stall_total;   // frozen cycles since reset
    int            freeze_cnt;    // frozen cycles seen, for directed checks

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic en, input logic r, input logic w, input logic [AW-1:0] dest,
                         input logic [DW-1:0] alu, input logic [DW-1:0] data, input logic rdy);
        bus.WB_EN_in    = en;
        bus.MEM_R_EN_in = r;
        bus.MEM_W_EN_in = w;
        bus.Dest_in     = dest;
        bus.ALU_res_in  = alu;
        bus.DATA_in     = data;
        bus.ready       = rdy;
    endtask

    task automatic model_reset();
        exp_en      = 1'b0;
        exp_dest    = '0;
        exp_val     = '0;
        exp_to      = 1'b0;
        stall_run   = 0;
        stall_total = '0;
    endtask

    // One clock: check outputs mid-cycle, then advance the model across the edge.
    task automatic tick();
        logic frz;
        @(negedge clk);
        frz = (bus.MEM_R_EN_in | bus.MEM_W_EN_in) & ~bus.ready;
        chk("freeze",   bus.freeze,   frz);
        chk("wb_en",    bus.WB_EN,    exp_en);
        chk("wb_dest",  bus.WB_Dest,  exp_dest);
        chk("wb_value", bus.WB_Value, exp_val);
        chk("timeout",  bus.timeout,  exp_to);
`ifdef MEM_WB_STALL_CNT_EN
        chk("stall_cycles", stall_cycles, stall_total);
`endif
        if (bus.freeze) freeze_cnt++;
        @(posedge clk);
        if (rst) begin
            if (!frz) begin
                exp_en    = bus.WB_EN_in;
                exp_dest  = bus.Dest_in;
                exp_val   = bus.MEM_R_EN_in ? bus.DATA_in : bus.ALU_res_in;
                stall_run = 0;
            end else begin
                exp_en      = 1'b0;
                stall_run   = stall_run + 1;
                stall_total = stall_total + 32'd1;
                if (stall_run >= WM) exp_to = 1'b1;
            end
        end
        #1;
    endtask

    // Memory access held for 'stalls' cycles, then completed with 'data'.
    task automatic mem_access(input logic en, input logic r, input logic w, input logic [AW-1:0] dest,
                              input logic [DW-1:0] alu, input logic [DW-1:0] data, input int stalls);
        for (int i = 0; i < stalls; i++) begin
            drive(en, r, w, dest, alu, DW'($urandom), 1'b0);
            tick();
        end
        drive(en, r, w, dest, alu, data, 1'b1);
        tick();
    endtask

    initial begin
        model_reset();
        freeze_cnt = 0;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);

        // Reset state
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_wb_en",    bus.WB_EN,    1'b0);
        chk("rst_wb_dest",  bus.WB_Dest,  '0);
        chk("rst_wb_value", bus.WB_Value, '0);
        chk("rst_timeout",  bus.timeout,  1'b0);
`ifdef MEM_WB_STALL_CNT_EN
        chk("rst_stall_cycles", stall_cycles, 32'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b1;

        // ALU passthrough
        freeze_cnt = 0;
        drive(1'b1, 1'b0, 1'b0, 4'd3, 32'h0000_0010, 32'h5555_AAAA, 1'b0);
        tick();
        chk("alu_wb_en",    bus.WB_EN,    1'b1);
        chk("alu_wb_dest",  bus.WB_Dest,  4'd3);
        chk("alu_wb_value", bus.WB_Value, 32'h10);
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
        tick();
        chk("alu_freeze_cnt", freeze_cnt, 0);

        // Load with a 4-cycle SRAM
        freeze_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 4'd5, 32'h0000_1000, DW'($urandom), 1'b0);
            tick();
            chk("load_stall_wb_en", bus.WB_EN, 1'b0);
        end
        drive(1'b1, 1'b1, 1'b0, 4'd5, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1);
        tick();
        chk("load_freeze_cnt", freeze_cnt, 4);
        chk("load_wb_en",      bus.WB_EN,    1'b1);
        chk("load_wb_dest",    bus.WB_Dest,  4'd5);
        chk("load_wb_value",   bus.WB_Value, 32'hDEAD_BEEF);

        // Store completing after 2 cycles
        freeze_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b1, 4'd7, 32'h0000_2000, '0, 1'b0);
            tick();
            chk("store_stall_wb_en", bus.WB_EN, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b1, 4'd7, 32'h0000_2000, '0, 1'b1);
        tick();
        chk("store_freeze_cnt", freeze_cnt, 2);
        chk("store_wb_en",      bus.WB_EN,  1'b0);
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        tick();

        // Timeout: ready held low for 20 cycles
        chk("to_before", bus.timeout, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, 1'b1, 1'b0, 4'd9, 32'h0000_3000, DW'($urandom), 1'b0);
            tick();
            if (i == 14) chk("to_wait14", bus.timeout, 1'b0);
            if (i == 15) chk("to_wait15", bus.timeout, 1'b1);
        end
        drive(1'b1, 1'b1, 1'b0, 4'd9, 32'h0000_3000, 32'h0000_1234, 1'b1);
        tick();
        chk("to_after_ready", bus.timeout,  1'b1);
        chk("to_load_value",  bus.WB_Value, 32'h1234);
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        tick();
        chk("to_sticky", bus.timeout, 1'b1);

        // Async reset in the middle of WAIT cycle 2
        drive(1'b1, 1'b1, 1'b0, 4'd2, 32'h0000_4000, 32'h0BAD_F00D, 1'b0);
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        chk("midrst_wb_en",    bus.WB_EN,    1'b0);
        chk("midrst_wb_value", bus.WB_Value, '0);
        chk("midrst_timeout",  bus.timeout,  1'b0);
        chk("midrst_freeze",   bus.freeze,   1'b1);
        model_reset();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Two loads with 3 stall cycles each
        mem_access(1'b1, 1'b1, 1'b0, 4'd1, 32'h10, 32'hCAFE_0001, 3);
        mem_access(1'b1, 1'b1, 1'b0, 4'd2, 32'h20, 32'hCAFE_0002, 3);
        chk("b2b_wb_value", bus.WB_Value, 32'hCAFE_0002);
        chk("b2b_timeout",  bus.timeout,  1'b0);
`ifdef MEM_WB_STALL_CNT_EN
        chk("b2b_stall_cycles", stall_cycles, 32'd6);
`endif
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        tick();

        // Randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            int kind;
            logic [AW-1:0] d;
            logic [DW-1:0] a;
            kind = int'($urandom_range(0, 3));
            d    = AW'($urandom);
            a    = DW'($urandom);
            case (kind)
                0: begin
                    drive(1'($urandom), 1'b0, 1'b0, d, a, DW'($urandom), 1'($urandom));
                    tick();
                end
                1: mem_access(1'b1, 1'b1, 1'b0, d, a, DW'($urandom), int'($urandom_range(0, 5)));
                2: mem_access(1'b0, 1'b0, 1'b1, d, a, DW'($urandom), int'($urandom_range(0, 5)));
                default: mem_access(1'b1, 1'b1, 1'b0, d, a, DW'($urandom),
                                    ($urandom_range(0, 9) == 0) ? 18 : 0);
            endcase
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline register and write-back select between the memory stage and the register file.
- Captures memory-stage results only when the SRAM controller reports the access complete.
- Generates the pipeline-wide freeze while an SRAM access is outstanding and inserts a bubble into write-back during the stall.
- Drives the register-file write port and the forwarding-unit inputs.

Parameters:
- DATA_W, 32, width of ALU result, load data and write-back value.
- REG_AW, 4, register index width (Dest).
- WAIT_MAX, 15, maximum WAIT cycles before the timeout flag sets.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- WB_EN_in  in  1  write-back enable from memory stage.
- MEM_R_EN_in  in  1  load in memory stage.
- MEM_W_EN_in  in  1  store in memory stage.
- Dest_in  in  REG_AW  destination register from memory stage.
- ALU_res_in  in  DATA_W  ALU result / address from memory stage.
- DATA_in  in  DATA_W  SRAM read data; valid when ready=1.
- ready  in  1  SRAM controller access-complete strobe.
- freeze  out  1  stall request to PC, IF/ID, ID/EX, EX/MEM registers.
- WB_EN  out  1  register-file write enable.
- WB_Dest  out  REG_AW  register-file write index.
- WB_Value  out  DATA_W  register-file write data.
- timeout  out  1  sticky: an access exceeded WAIT_MAX cycles.

Behaviour:
- Reset (rst=0, async): state=RUN; WB_EN=0; WB_Dest=0; WB_Value=0; internal data/ALU/MEM_R registers=0; timeout=0; wait counter=0.
- mem_op = MEM_R_EN_in | MEM_W_EN_in.
- freeze = mem_op & ~ready. It is combinational, so it is asserted in the same cycle as the stall. Upstream holds all *_in stable while freeze=1.
- FSM states:
  - RUN → WAIT when mem_op & ~ready.
  - WAIT → RUN when ready=1.
  - WAIT stays in WAIT otherwise.
- Capture when freeze=0, registered on the next edge: WB_EN_r←WB_EN_in, Dest_r←Dest_in, ALU_r←ALU_res_in, MEM_R_r←MEM_R_EN_in, DATA_r←DATA_in.
- Bubble when freeze=1: WB_EN_r←0. Dest, ALU, DATA and MEM_R registers hold.
- Latency: 1 cycle from the capture edge to WB outputs, for both ALU ops and completed loads.
- WB_Value = MEM_R_r ? DATA_r : ALU_r. WB_Dest = Dest_r. WB_EN = WB_EN_r. All are combinational from registers.
- Store: WB_EN_in is 0 by decode, so a completed store yields a bubble (WB_EN=0).
- ready=1 with mem_op=0 is ignored. A non-memory instruction passes with no stall.
- Ready in the same cycle as the request: no stall, no WAIT entry, immediate capture.
- Wait counter:
  - Cleared on entry to RUN.
  - Increments each WAIT cycle and saturates at WAIT_MAX.
  - Reaching WAIT_MAX sets timeout. timeout clears only on reset.
  - The FSM keeps waiting after timeout; the flag does not abort the access.
- Reset mid-WAIT: immediate return to RUN, outputs cleared, freeze follows inputs combinationally.
- Back-to-back loads: each load stalls independently. The second load's capture overwrites DATA_r only after the first has been presented for one cycle.

Optional Feature:
- MEM_WB_STALL_CNT_EN defined: adds output stall_cycles [31:0].
  - Counts cycles with freeze=1, wraps at 2^32, resets to 0.
- Not defined: port and counter are absent. No other behaviour changes.

Decomposition:
- Shared package holds:
  - the state typedef {RUN, WAIT};
  - DATA_W and REG_AW defaults;
  - the counter width localparam (clog2 of WAIT_MAX+1).
- One natural sub-module, wb_select: the combinational load/ALU mux producing WB_Value. It is reused by the forwarding path.

Test Plan:
- ALU op passthrough: WB_EN_in=1, Dest_in=3, ALU_res_in=0x0000_0010, mem_op=0 → next cycle WB_EN=1, WB_Dest=3, WB_Value=0x10, freeze never 1.
- Load with 4-cycle SRAM: MEM_R_EN_in=1, Dest_in=5, ready low 4 cycles then DATA_in=0xDEAD_BEEF, ready=1.
  - freeze=1 for exactly 4 cycles and WB_EN=0 during them.
  - Cycle after ready: WB_EN=1, WB_Dest=5, WB_Value=0xDEADBEEF.
- Store with ready after 2 cycles: freeze=1 for 2 cycles, WB_EN stays 0 throughout, FSM back in RUN.
- Timeout: load with ready held low 20 cycles, WAIT_MAX=15 → timeout=1 at the 15th WAIT cycle and stays 1 after ready.
- Async reset mid-WAIT: assert rst=0 at WAIT cycle 2 between edges → WB_EN=0, WB_Value=0, timeout=0 immediately. After release, FSM is in RUN.
- MEM_WB_STALL_CNT_EN build: two loads each with 3 stall cycles → stall_cycles=6.
